button_conditioner: RTL and testbench

Input conditioning stage between the board push-buttons and the stopwatch control logic. It synchronizes each raw button to `clk`, debounces it, and produces a clean level, a one-cycle press pulse and a one-cycle release pulse per button. Channels with auto-repeat enabled also re-issue press pulses while held, for stepping digits in time-set mode. It directly feeds the `start`, `stop`, `lap` and `clr` controls of the stopwatch core.

---
 rtl/button_conditioner.sv | 133 +++++++++++++
 tb/tb_button_conditioner.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button input conditioner for the stopwatch.
// Each channel runs independently through three stages:
//   1. A two-flop synchronizer.
//   2. A debouncer that outputs a clean level plus one-cycle press/release pulses.
//   3. An optional auto-repeat FSM that re-issues press pulses while the button is held.
// Handshake: no valid/ready handshake exists here. Every output is a registered
// level or a one-cycle pulse that the consumer samples on every clk edge.
module button_conditioner #(
  parameter int              N_BTN           = 4,
  parameter int              DEBOUNCE_CYCLES = 1_000_000,
  parameter int              HOLD_CYCLES     = 50_000_000,
  parameter int              REPEAT_CYCLES   = 20_000_000,
  parameter logic [N_BTN-1:0] REPEAT_EN      = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_held
);

  localparam int DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int HW       = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HOLD = 2'd1,
    REPEAT    = 2'd2
  } rpt_state_t;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    logic          sync1;
    logic          sync2;
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          held_r;
    logic [DW-1:0] db_cnt;
    logic [HW-1:0] hold_cnt;
    rpt_state_t    state;
    logic          settle;
    logic          rise;
    logic          fall;

    // A level change is accepted on the edge where the disagreement count
    // would reach DEBOUNCE_CYCLES.
    always_comb begin
      settle = (sync2 != level_r) && (db_cnt == DW'(DEBOUNCE_CYCLES - 1));
      rise   = settle && sync2;
      fall   = settle && !sync2;
    end

    // Synchronizer, debounce counter and auto-repeat FSM; all outputs registered.
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1     <= 1'b0;
        sync2     <= 1'b0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        held_r    <= 1'b0;
        db_cnt    <= '0;
        hold_cnt  <= '0;
        state     <= IDLE;
      end else begin
        sync1     <= btn_raw[i];
        sync2     <= sync1;
        press_r   <= rise;
        release_r <= fall;

        // Any agreeing cycle restarts the count, which rejects glitches.
        if (sync2 == level_r) begin
          db_cnt <= '0;
        end else if (settle) begin
          level_r <= sync2;
          db_cnt  <= '0;
        end else begin
          db_cnt <= db_cnt + DW'(1);
        end

        if (REPEAT_EN[i]) begin
          if (fall) begin
            // A release wins over a repeat that falls due on the same edge.
            state    <= IDLE;
            held_r   <= 1'b0;
            hold_cnt <= '0;
          end else begin
            case (state)
              IDLE: begin
                if (rise) begin
                  state    <= WAIT_HOLD;
                  hold_cnt <= '0;
                end
              end
              WAIT_HOLD: begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                  press_r  <= 1'b1;
                  held_r   <= 1'b1;
                  hold_cnt <= '0;
                  state    <= REPEAT;
                end else begin
                  hold_cnt <= hold_cnt + HW'(1);
                end
              end
              REPEAT: begin
                if (hold_cnt == HW'(REPEAT_CYCLES - 1)) begin
                  press_r  <= 1'b1;
                  hold_cnt <= '0;
                end else begin
                  hold_cnt <= hold_cnt + HW'(1);
                end
              end
              default: begin
                state    <= IDLE;
                hold_cnt <= '0;
                held_r   <= 1'b0;
              end
            endcase
          end
        end
      end
    end

    assign btn_level[i]   = level_r;
    assign btn_press[i]   = press_r;
    assign btn_release[i] = release_r;
    assign btn_held[i]    = held_r;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner.
// It uses short debounce, hold and repeat timings so that every scenario runs quickly.
module tb_button_conditioner;

  localparam int N    = 4;
  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int LAT  = DEB + 2;  // edges from first raw sample to accepted level

  logic         clk;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;
  logic [N-1:0] btn_held;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 0;

  // Entry: {cycle[31:0], press[3:0], release[3:0]}
  logic [39:0] exp_q[$];

  button_conditioner #(
    .N_BTN(N), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD),
    .REPEAT_CYCLES(REP), .REPEAT_EN(4'b0100)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_held(btn_held)
  );

  // Clock and edge counter: after posedge k, cyc == k.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every observed pulse must match the head of the expected queue.
  always @(negedge clk) begin
    logic [39:0] e;
    if (mon_en && (btn_press !== 4'b0 || btn_release !== 4'b0)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d press=%b release=%b, expected no pulse",
                 cyc, btn_press, btn_release);
      end else begin
        e = exp_q.pop_front();
        if ({32'(cyc), btn_press, btn_release} !== e) begin
          errors++;
          $display("FAIL pulse cyc=%0d press=%b release=%b, expected cyc=%0d press=%b release=%b",
                   cyc, btn_press, btn_release, e[39:8], e[7:4], e[3:0]);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_to(input int t);
    while (cyc < t) step(1);
  endtask

  function automatic void push_exp(input int t, input logic [3:0] p, input logic [3:0] r);
    exp_q.push_back({32'(t), p, r});
  endfunction

  task automatic test_reset;
    int c;
    rst = 1'b1;
    btn_raw = 4'b1111;
    step(1);
    mon_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({btn_level, btn_press, btn_release, btn_held} !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs cyc=%0d got=%h expected=0000", cyc,
                 {btn_level, btn_press, btn_release, btn_held});
      end
      if (k < 2) step(1);
    end
    rst = 1'b0;
    c = cyc;
    push_exp(c + LAT, 4'b1111, 4'b0000);
    step_to(c + LAT - 1);
    checks++;
    if (btn_level !== 4'b0000) begin
      errors++;
      $display("FAIL reset_level_early got=%b expected=0000", btn_level);
    end
    step(1);
    checks++;
    if (btn_level !== 4'b1111) begin
      errors++;
      $display("FAIL reset_level_accept got=%b expected=1111", btn_level);
    end
    btn_raw = 4'b0000;
    push_exp(c + 2 * LAT, 4'b0000, 4'b1111);
    step_to(c + 2 * LAT);
    checks++;
    if (btn_level !== 4'b0000 || btn_held !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release level=%b held=%b expected=0000/0000", btn_level, btn_held);
    end
    step(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_missing_pulses pending=%0d expected=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_press_release;
    int c;
    c = cyc;
    btn_raw[0] = 1'b1;
    push_exp(c + LAT, 4'b0001, 4'b0000);
    step_to(c + LAT - 1);
    checks++;
    if (btn_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL ch0_level_early got=%b expected=0", btn_level[0]);
    end
    step(1);
    checks++;
    if (btn_level !== 4'b0001) begin
      errors++;
      $display("FAIL ch0_level_high got=%b expected=0001", btn_level);
    end
    step_to(c + 10);
    btn_raw[0] = 1'b0;
    push_exp(c + 10 + LAT, 4'b0000, 4'b0001);
    step_to(c + 10 + LAT - 1);
    checks++;
    if (btn_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL ch0_level_hold got=%b expected=1", btn_level[0]);
    end
    step(1);
    checks++;
    if (btn_level !== 4'b0000) begin
      errors++;
      $display("FAIL ch0_level_low got=%b expected=0000", btn_level);
    end
    step(5);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ch0_missing_pulses pending=%0d expected=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_bounce;
    for (int k = 0; k < 5; k++) begin
      btn_raw[1] = 1'b1;
      step(3);
      btn_raw[1] = 1'b0;
      step(1);
    end
    step(12);
    checks++;
    if (btn_level !== 4'b0000) begin
      errors++;
      $display("FAIL bounce_level got=%b expected=0000", btn_level);
    end
  endtask

  task automatic test_auto_repeat;
    int p;
    btn_raw[2] = 1'b1;
    p = cyc + LAT;
    push_exp(p, 4'b0100, 4'b0000);
    push_exp(p + HOLD, 4'b0100, 4'b0000);
    for (int k = 1; k <= 5; k++) push_exp(p + HOLD + k * REP, 4'b0100, 4'b0000);
    step_to(p + HOLD - 1);
    checks++;
    if (btn_held !== 4'b0000) begin
      errors++;
      $display("FAIL ch2_held_early got=%b expected=0000", btn_held);
    end
    step(1);
    checks++;
    if (btn_held !== 4'b0100) begin
      errors++;
      $display("FAIL ch2_held_rise got=%b expected=0100", btn_held);
    end
    step_to(p + 60);
    btn_raw[2] = 1'b0;
    push_exp(p + 60 + LAT, 4'b0000, 4'b0100);
    step_to(p + 60 + LAT - 1);
    checks++;
    if (btn_held !== 4'b0100 || btn_level !== 4'b0100) begin
      errors++;
      $display("FAIL ch2_before_release held=%b level=%b expected=0100/0100", btn_held, btn_level);
    end
    step(1);
    checks++;
    if (btn_held !== 4'b0000 || btn_level !== 4'b0000) begin
      errors++;
      $display("FAIL ch2_release held=%b level=%b expected=0000/0000", btn_held, btn_level);
    end
    step(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ch2_missing_pulses pending=%0d expected=0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_repeat_disabled;
    int p;
    btn_raw[3] = 1'b1;
    p = cyc + LAT;
    push_exp(p, 4'b1000, 4'b0000);
    step_to(p + HOLD);
    checks++;
    if (btn_held !== 4'b0000 || btn_level !== 4'b1000) begin
      errors++;
      $display("FAIL ch3_hold held=%b level=%b expected=0000/1000", btn_held, btn_level);
    end
    step_to(p + 60);
    btn_raw[3] = 1'b0;
    push_exp(p + 60 + LAT, 4'b0000, 4'b1000);
    step_to(p + 60 + LAT + 5);
    checks++;
    if (exp_q.size() != 0 || btn_held !== 4'b0000) begin
      errors++;
      $display("FAIL ch3_pulses pending=%0d held=%b expected=0/0000", exp_q.size(), btn_held);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid;
    int p;
    int r;
    btn_raw[2] = 1'b1;
    p = cyc + LAT;
    push_exp(p, 4'b0100, 4'b0000);
    step_to(p + 10);
    rst = 1'b1;
    step(1);
    checks++;
    if ({btn_level, btn_press, btn_release, btn_held} !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_outputs got=%h expected=0000",
               {btn_level, btn_press, btn_release, btn_held});
    end
    rst = 1'b0;
    r = cyc;
    p = r + LAT;
    push_exp(p, 4'b0100, 4'b0000);
    push_exp(p + HOLD, 4'b0100, 4'b0000);
    step_to(p + HOLD - 1);
    checks++;
    if (btn_held !== 4'b0000 || btn_level !== 4'b0100) begin
      errors++;
      $display("FAIL mid_reset_rehold held=%b level=%b expected=0000/0100", btn_held, btn_level);
    end
    step(1);
    checks++;
    if (btn_held !== 4'b0100) begin
      errors++;
      $display("FAIL mid_reset_held got=%b expected=0100", btn_held);
    end
    btn_raw[2] = 1'b0;
    push_exp(p + HOLD + LAT, 4'b0000, 4'b0100);
    step_to(p + HOLD + LAT + 10);
    checks++;
    if (exp_q.size() != 0 || btn_held !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_pulses pending=%0d held=%b expected=0/0000", exp_q.size(), btn_held);
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    btn_raw = 4'b0000;
    test_reset();
    test_press_release();
    test_bounce();
    test_auto_repeat();
    test_repeat_disabled();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
